// File: rtl/jt12_fm_acc.sv
// jt12_fm_acc: FM frame accumulator.
// Walks the 24 operator slots of an FM frame, sums the carrier outputs of
// the enabled channels (channel 5 may be replaced by the PCM DAC) and emits
// one saturated signed sample per frame when the next frame-start slot
// arrives. The accumulator must be wider than the output (ACCW > OUTW).
module jt12_fm_acc #(
  parameter int OPW  = 14,
  parameter int OUTW = 16,
  parameter int ACCW = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   zero,
  input  logic signed [OPW-1:0]  op_out,
  input  logic                   is_carrier,
  input  logic [5:0]             ch_en,
  input  logic                   pcm_en,
  input  logic signed [8:0]      pcm,
  output logic signed [OUTW-1:0] fm_snd,
  output logic                   snd_stb,
  output logic                   sat_flag
);

  localparam logic [4:0] LAST_SLOT  = 5'd23;
  localparam logic [4:0] OP4_FIRST  = 5'd18;
  localparam logic [2:0] LAST_CH    = 3'd5;

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [OUTW-1:0] OUT_MAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] OUT_MIN = {1'b1, {(OUTW-1){1'b0}}};

  logic [4:0]             slot;
  logic [2:0]             ch;
  logic signed [ACCW-1:0] acc;

  logic [4:0]             cur_slot;
  logic [2:0]             cur_ch;
  logic signed [ACCW-1:0] op_ext;
  logic signed [ACCW-1:0] pcm_ext;
  logic signed [ACCW-1:0] contrib;
  logic signed [ACCW:0]   sum_wide;
  logic signed [ACCW-1:0] acc_next;
  logic                   out_hi;
  logic                   out_lo;
  logic signed [OUTW-1:0] out_sat;

  // The zero slot is slot 0 / channel 0 regardless of where the counters sit.
  always_comb begin
    cur_slot = zero ? 5'd0 : slot;
    cur_ch   = zero ? 3'd0 : ch;
  end

  // Sign-extend the operator and the PCM sample (PCM scaled up by 32).
  always_comb begin
    op_ext  = {{(ACCW-OPW){op_out[OPW-1]}}, op_out};
    pcm_ext = {{(ACCW-14){pcm[8]}}, pcm, 5'b0};
  end

  // Contribution of the current slot. With PCM on, channel 5 FM is muted and
  // the DAC value is injected once, on channel 5's op4 slot.
  always_comb begin
    contrib = '0;
    if (cur_ch == LAST_CH && pcm_en) begin
      if (cur_slot >= OP4_FIRST)
        contrib = pcm_ext;
    end else if (is_carrier && ch_en[cur_ch]) begin
      contrib = op_ext;
    end
  end

  // Accumulate with one guard bit and clamp to the accumulator range.
  always_comb begin
    sum_wide = {acc[ACCW-1], acc} + {contrib[ACCW-1], contrib};
    if (sum_wide[ACCW] != sum_wide[ACCW-1])
      acc_next = sum_wide[ACCW] ? ACC_MIN : ACC_MAX;
    else
      acc_next = sum_wide[ACCW-1:0];
  end

  // Clamp the frame total to the output width.
  always_comb begin
    out_hi  = !acc[ACCW-1] && (|acc[ACCW-2:OUTW-1]);
    out_lo  =  acc[ACCW-1] && !(&acc[ACCW-2:OUTW-1]);
    if (out_hi)
      out_sat = OUT_MAX;
    else if (out_lo)
      out_sat = OUT_MIN;
    else
      out_sat = acc[OUTW-1:0];
  end

  // Slot/channel counters: resync on zero, otherwise free-run and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      ch   <= '0;
    end else if (cen) begin
      if (zero) begin
        slot <= 5'd1;
        ch   <= 3'd1;
      end else begin
        slot <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
        ch   <= (ch == LAST_CH) ? 3'd0 : ch + 3'd1;
      end
    end
  end

  // Accumulator: the zero slot restarts the sum with its own contribution.
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (cen)
      acc <= zero ? contrib : acc_next;
  end

  // Frame close: publish the previous total, pulse the strobe, latch clamping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fm_snd   <= '0;
      snd_stb  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      snd_stb <= 1'b0;
      if (cen && zero) begin
        fm_snd  <= out_sat;
        snd_stb <= 1'b1;
        if (out_hi || out_lo)
          sat_flag <= 1'b1;
      end
    end
  end

endmodule
